// File: rtl/pixel_scheduler.sv
// pixel_scheduler: raster-order sequencer in front of depth_calculator.
// Walks every pixel of a frame, keeps Re(c)/Im(c) as running sums, launches
// one depth calculation per pixel, and forwards (x, y, depth) downstream on
// a valid/ready stream. Only one calculation is ever outstanding.

module pixel_scheduler #(
    parameter int H_RES = 640,
    parameter int V_RES = 480,
    parameter int FRAC  = 16
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic        frame_start,
    input  logic [31:0] re_min,
    input  logic [31:0] im_max,
    input  logic [31:0] step,
    output logic        frame_busy,
    output logic        frame_done,
    output logic        calc_start,
    output logic [9:0]  calc_x,
    output logic [8:0]  calc_y,
    output logic [31:0] calc_re_c,
    output logic [31:0] calc_im_c,
    input  logic        calc_done,
    input  logic [7:0]  calc_depth,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic [9:0]  pix_x,
    output logic [8:0]  pix_y,
    output logic [7:0]  pix_depth,
    output logic        pix_sof,
    output logic        pix_last
);

    // Geometry beyond the coordinate widths, or a fraction wider than the
    // word, cannot be represented; refuse to elaborate rather than wrap.
    generate
        if (H_RES < 1 || H_RES > 1024 || V_RES < 1 || V_RES > 512 ||
            FRAC < 0 || FRAC > 31) begin : g_bad_params
            $error("pixel_scheduler: H_RES/V_RES/FRAC out of range");
        end
    endgenerate

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LAUNCH = 3'd1;
    localparam logic [2:0] ST_ARM    = 3'd2;
    localparam logic [2:0] ST_WAIT   = 3'd3;
    localparam logic [2:0] ST_EMIT   = 3'd4;

    localparam logic [9:0] X_LAST = 10'(H_RES - 1);
    localparam logic [8:0] Y_LAST = 9'(V_RES - 1);

    logic [2:0]  state;
    logic [9:0]  x_pos;
    logic [8:0]  y_pos;
    logic [31:0] re_acc;
    logic [31:0] im_acc;
    logic [31:0] re_base;
    logic [31:0] step_reg;

    logic start_ok;
    logic accept;
    logic line_end;
    logic frame_end;

    // A start pulse coinciding with frame_done is dropped so a frame always
    // begins from a clean IDLE cycle.
    assign start_ok  = (state == ST_IDLE) && frame_start && !frame_done;
    assign accept    = (state == ST_EMIT) && pix_valid && pix_ready;
    assign line_end  = (x_pos == X_LAST);
    assign frame_end = line_end && (y_pos == Y_LAST);

    assign calc_start = (state == ST_LAUNCH);
    assign calc_x     = x_pos;
    assign calc_y     = y_pos;
    assign calc_re_c  = re_acc;
    assign calc_im_c  = im_acc;

    // Sequencer: launch, blind cycle, wait for result, hand off, repeat.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            frame_busy <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        state      <= ST_LAUNCH;
                        frame_busy <= 1'b1;
                    end
                end
                ST_LAUNCH: state <= ST_ARM;
                ST_ARM:    state <= ST_WAIT;
                ST_WAIT: begin
                    if (calc_done) begin
                        state <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (accept) begin
                        if (frame_end) begin
                            state      <= ST_IDLE;
                            frame_busy <= 1'b0;
                            frame_done <= 1'b1;
                        end else begin
                            state <= ST_LAUNCH;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Position and c accumulators; frame parameters are latched only at start.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            x_pos    <= '0;
            y_pos    <= '0;
            re_acc   <= '0;
            im_acc   <= '0;
            re_base  <= '0;
            step_reg <= '0;
        end else if (start_ok) begin
            x_pos    <= '0;
            y_pos    <= '0;
            re_acc   <= re_min;
            im_acc   <= im_max;
            re_base  <= re_min;
            step_reg <= step;
        end else if (accept) begin
            if (line_end) begin
                x_pos  <= '0;
                y_pos  <= y_pos + 9'd1;
                re_acc <= re_base;
                im_acc <= im_acc - step_reg;
            end else begin
                x_pos  <= x_pos + 10'd1;
                re_acc <= re_acc + step_reg;
            end
        end
    end

    // Output pixel register: captured from the calculator in WAIT, held until taken.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            pix_valid <= 1'b0;
            pix_x     <= '0;
            pix_y     <= '0;
            pix_depth <= '0;
            pix_sof   <= 1'b0;
            pix_last  <= 1'b0;
        end else if (state == ST_WAIT && calc_done) begin
            pix_valid <= 1'b1;
            pix_x     <= x_pos;
            pix_y     <= y_pos;
            pix_depth <= calc_depth;
            pix_sof   <= (x_pos == 10'd0) && (y_pos == 9'd0);
            pix_last  <= line_end;
        end else if (accept) begin
            pix_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pixel_scheduler.sv
// tb_pixel_scheduler: directed bench for pixel_scheduler on a 4x3 frame.
// A small calculator model answers each launch; a per-cycle compare process
// checks launches and emitted pixels against a raster/arithmetic model.

module tb_pixel_scheduler;

    localparam int H = 4;
    localparam int V = 3;

    logic        sysclk = 1'b0;
    logic        reset = 1'b1;
    logic        frame_start = 1'b0;
    logic [31:0] re_min = '0;
    logic [31:0] im_max = '0;
    logic [31:0] step = '0;
    logic        frame_busy, frame_done, calc_start;
    logic [9:0]  calc_x;
    logic [8:0]  calc_y;
    logic [31:0] calc_re_c, calc_im_c;
    logic        calc_done = 1'b0;
    logic [7:0]  calc_depth = '0;
    logic        pix_valid;
    logic        pix_ready = 1'b1;
    logic [9:0]  pix_x;
    logic [8:0]  pix_y;
    logic [7:0]  pix_depth;
    logic        pix_sof, pix_last;

    pixel_scheduler #(.H_RES(H), .V_RES(V), .FRAC(16)) dut (
        .sysclk(sysclk), .reset(reset), .frame_start(frame_start),
        .re_min(re_min), .im_max(im_max), .step(step),
        .frame_busy(frame_busy), .frame_done(frame_done), .calc_start(calc_start),
        .calc_x(calc_x), .calc_y(calc_y), .calc_re_c(calc_re_c), .calc_im_c(calc_im_c),
        .calc_done(calc_done), .calc_depth(calc_depth),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_x(pix_x), .pix_y(pix_y), .pix_depth(pix_depth),
        .pix_sof(pix_sof), .pix_last(pix_last)
    );

    always #5 sysclk = ~sysclk;

    int errors = 0;
    int checks = 0;

    // model state
    logic [31:0] m_re, m_im, m_step;
    int m_salt = 0;
    int mx = 0, my = 0;
    bit active = 0, launched = 0, done_due = 0, chk_en = 0;
    int pix_count = 0, start_count = 0, frames_done = 0, hold_cycles = 0;
    bit hold_pending = 0;
    logic [9:0] h_x; logic [8:0] h_y; logic [7:0] h_d; logic h_sof, h_last;
    logic [31:0] cap_re10 = '0, cap_re32 = '0, cap_im32 = '0;
    logic [7:0] cap_depth = '0;

    // calculator / sink model controls
    int latency = 5, stale_hold = 1;
    bit pend = 0; int cnt = 0; logic [7:0] dep_next = '0;
    bit stall_en = 0; int stall_x = 0, stall_y = 0, stall_cnt = 0;

    function automatic logic [7:0] depth_of(int x, int y, int salt);
        return 8'(x * 29 + y * 7 + salt);
    endfunction

    task automatic check_output(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_cycle();
        logic [31:0] ex_re, ex_im;
        @(negedge sysclk);
        if (!chk_en) return;
        ex_re = m_re + 32'(mx) * m_step;
        ex_im = m_im - 32'(my) * m_step;
        check_output("frame_done", {31'd0, frame_done}, {31'd0, done_due});
        if (frame_done) frames_done++;
        done_due = 0;
        if (hold_pending) begin
            check_output("hold_valid", {31'd0, pix_valid}, 32'd1);
            check_output("hold_fields", {pix_x, pix_y, pix_depth, pix_sof, pix_last},
                         {h_x, h_y, h_d, h_sof, h_last});
            check_output("hold_no_start", {31'd0, calc_start}, 32'd0);
        end
        hold_pending = 0;
        if (calc_start) begin
            start_count++;
            check_output("start_allowed", {31'd0, active && !launched}, 32'd1);
            check_output("calc_x", {22'd0, calc_x}, 32'(mx));
            check_output("calc_y", {23'd0, calc_y}, 32'(my));
            check_output("calc_re_c", calc_re_c, ex_re);
            check_output("calc_im_c", calc_im_c, ex_im);
            if (mx == 1 && my == 0) cap_re10 = calc_re_c;
            if (mx == 3 && my == 2) begin cap_re32 = calc_re_c; cap_im32 = calc_im_c; end
            launched = 1;
        end
        if (calc_start || pix_valid)
            check_output("busy", {31'd0, frame_busy}, 32'd1);
        if (pix_valid) begin
            check_output("pix_launched", {31'd0, launched}, 32'd1);
            check_output("pix_x", {22'd0, pix_x}, 32'(mx));
            check_output("pix_y", {23'd0, pix_y}, 32'(my));
            check_output("pix_depth", {24'd0, pix_depth}, {24'd0, depth_of(mx, my, m_salt)});
            check_output("pix_sof", {31'd0, pix_sof}, {31'd0, mx == 0 && my == 0});
            check_output("pix_last", {31'd0, pix_last}, {31'd0, mx == H - 1});
            if (pix_ready) begin
                pix_count++;
                launched = 0;
                if (mx == H - 1 && my == V - 1) begin
                    cap_depth = pix_depth;
                    active = 0;
                    done_due = 1;
                end else if (mx == H - 1) begin
                    mx = 0; my++;
                end else begin
                    mx++;
                end
            end else begin
                hold_cycles++;
                hold_pending = 1;
                h_x = pix_x; h_y = pix_y; h_d = pix_depth; h_sof = pix_sof; h_last = pix_last;
            end
        end
        if (frame_done)
            check_output("busy_at_done", {31'd0, frame_busy}, 32'd0);
    endtask

    task automatic drive_cycle();
        @(posedge sysclk);
        #1;
        if (calc_start) begin
            pend = 1; cnt = 0; dep_next = depth_of(int'(calc_x), int'(calc_y), m_salt);
        end else if (pend) begin
            cnt++;
            if (cnt == stale_hold) calc_done = 1'b0;
            if (cnt == latency) begin
                calc_done = 1'b1; calc_depth = dep_next; pend = 0;
            end
        end
        if (stall_en && pix_valid && int'(pix_x) == stall_x && int'(pix_y) == stall_y
            && stall_cnt < 7) begin
            pix_ready = 1'b0; stall_cnt++;
        end else begin
            pix_ready = 1'b1;
        end
    endtask

    task automatic apply_frame(logic [31:0] re, logic [31:0] im, logic [31:0] st,
                               int salt, int stale);
        @(posedge sysclk); #2;
        re_min = re; im_max = im; step = st;
        m_re = re; m_im = im; m_step = st; m_salt = salt; stale_hold = stale;
        mx = 0; my = 0; active = 1; launched = 0; done_due = 0; hold_pending = 0;
        pix_count = 0; start_count = 0; frames_done = 0; hold_cycles = 0;
        chk_en = 1; frame_start = 1'b1;
        @(posedge sysclk); #2;
        frame_start = 1'b0;
    endtask

    task automatic pulse_junk_start();
        re_min = 32'hDEAD_BEEF; im_max = 32'h1234_5678; step = 32'h0F0F_0F0F;
        frame_start = 1'b1;
        @(posedge sysclk); #2;
        frame_start = 1'b0;
    endtask

    task automatic wait_frame_done(bit pulse_on_done);
        bit seen = 0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(posedge sysclk); #2;
            if (frame_done) seen = 1;
        end
        if (!seen) check_output("frame_done_timeout", 32'd0, 32'd1);
        else if (pulse_on_done) pulse_junk_start();
        repeat (3) @(negedge sysclk);
        #1;
    endtask

    task automatic check_all_zero(string tag);
        check_output({tag, "_ctl"}, {29'd0, frame_busy, frame_done, calc_start}, 32'd0);
        check_output({tag, "_cxy"}, {13'd0, calc_x, calc_y}, 32'd0);
        check_output({tag, "_cre"}, calc_re_c, 32'd0);
        check_output({tag, "_cim"}, calc_im_c, 32'd0);
        check_output({tag, "_pix"}, {4'd0, pix_valid, pix_x, pix_y, pix_depth, pix_sof, pix_last},
                     32'd0);
    endtask

    initial begin
        fork
            forever compare_cycle();
            forever drive_cycle();
        join_none

        // reset state
        #1;
        check_all_zero("reset_state");
        repeat (3) @(posedge sysclk);
        #2 reset = 1'b0;

        // frame A: raster order, sof/last, coordinate values
        apply_frame(32'hFFFE_0000, 32'h0001_0000, 32'h0000_8000, 0, 1);
        wait_frame_done(0);
        check_output("A_pix_count", 32'(pix_count), 32'd12);
        check_output("A_starts", 32'(start_count), 32'd12);
        check_output("A_frames_done", 32'(frames_done), 32'd1);
        check_output("A_re_1_0", cap_re10, 32'hFFFE_8000);
        check_output("A_re_3_2", cap_re32, 32'hFFFF_8000);
        check_output("A_im_3_2", cap_im32, 32'h0000_0000);
        check_output("A_last_depth", {24'd0, cap_depth}, 32'd101);

        // frame B: stale done through ARM, backpressure, ignored restarts
        stall_en = 1; stall_x = 1; stall_y = 1; stall_cnt = 0;
        apply_frame(32'h0010_0000, 32'hFFF0_0000, 32'h0000_1234, 3, 2);
        for (int i = 0; i < 2000 && pix_count < 6; i++) begin
            @(posedge sysclk); #2;
        end
        check_output("B_reached_mid", {31'd0, pix_count >= 6}, 32'd1);
        pulse_junk_start();
        wait_frame_done(1);
        repeat (20) @(posedge sysclk);
        #2;
        check_output("B_pix_count", 32'(pix_count), 32'd12);
        check_output("B_starts", 32'(start_count), 32'd12);
        check_output("B_frames_done", 32'(frames_done), 32'd1);
        check_output("B_hold_cycles", 32'(hold_cycles), 32'd7);
        check_output("B_idle_busy", {31'd0, frame_busy}, 32'd0);
        stall_en = 0;

        // frame C: reset while waiting on pixel (2,1)
        apply_frame(32'h0000_0100, 32'h0000_0200, 32'h0000_0010, 5, 1);
        begin
            bit hit = 0;
            for (int i = 0; i < 2000 && !hit; i++) begin
                @(posedge sysclk); #2;
                if (calc_start && calc_x == 10'd2 && calc_y == 9'd1) hit = 1;
            end
            check_output("C_reached_2_1", {31'd0, hit}, 32'd1);
        end
        @(posedge sysclk); #2;
        @(posedge sysclk); #2;
        chk_en = 0;
        reset = 1'b1;
        #1;
        check_all_zero("mid_reset");
        repeat (2) @(posedge sysclk);
        #1;
        check_all_zero("held_reset");
        check_output("C_no_done", 32'(frames_done), 32'd0);
        @(posedge sysclk); #2;
        reset = 1'b0;

        // frame D: restart from (0,0) with new inputs, wrapping arithmetic
        apply_frame(32'h7FFF_8000, 32'h8000_4000, 32'h0000_8000, 9, 1);
        wait_frame_done(0);
        check_output("D_pix_count", 32'(pix_count), 32'd12);
        check_output("D_frames_done", 32'(frames_done), 32'd1);
        check_output("D_re_1_0", cap_re10, 32'h8000_0000);
        check_output("D_re_3_2", cap_re32, 32'h8001_0000);
        check_output("D_im_3_2", cap_im32, 32'h7FFF_4000);
        check_output("D_last_depth", {24'd0, cap_depth}, 32'd110);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
